data_mem: RTL and testbench
===========================

DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset: clk rises-edge clocks all state; rst clears state immediately, independent of clk.
REQ-002 SHALL have port clk, input, 1 bit: sole clock.
REQ-003 SHALL have port rst, input, 1 bit: async active-high reset.
REQ-004 SHALL have port mem_data, inout, 64 bits: shared data bus, written by the CPU when mem_rw=1, driven by this block on reads.
REQ-005 SHALL have port mem_rw, input, 1 bit: 1 = CPU store this cycle, 0 = read/idle.
REQ-006 SHALL have port addr, input, 64 bits: byte address from the CPU result bus.
REQ-007 SHALL have port halt, input, 1 bit: level; CPU has retired halt.
REQ-008 SHALL have port done, output, 1 bit: halt scan complete.
REQ-009 SHALL have port checksum, output, 64 bits: sum of all valid words.
REQ-010 SHALL have port wr_count, output, 16 bits: accepted stores.
REQ-011 SHALL have port addr_err, output, 1 bit: sticky out-of-range access flag.
REQ-012 SHALL have parameter DEPTH, default 1024, meaning number of 64-bit words; index = addr[12:3].

Function
REQ-013 SHALL hold storage of DEPTH x 64-bit words plus one valid bit per word.
REQ-014 SHALL treat an address as in range when addr[63:13]==0; addr[2:0] ignored (word aligned).
REQ-015 SHALL perform a store in RUN state on the clk edge where mem_rw=1 and addr is in range: word <= mem_data, valid <= 1, wr_count += 1 (wraps 0xFFFF->0).
REQ-016 SHALL drive mem_data combinationally in RUN when mem_rw=0: in-range valid word -> stored value; invalid word or out-of-range -> 0 (zero-latency read, usable in the same cycle).
REQ-017 SHALL release mem_data (high-Z) whenever mem_rw=1, rst=1, or state is not RUN; never drive it at the same time as the CPU.
REQ-018 SHALL set addr_err on any clk edge in RUN with addr out of range and mem_rw=1; an out-of-range store is discarded and does not count. addr_err stays set until rst.
REQ-019 SHALL implement FSM states RUN, SCAN, DONE; reset state RUN.
REQ-020 SHALL transition RUN->SCAN on the clk edge where halt=1, clearing the scan index and checksum; a store presented on the same edge is still performed.
REQ-021 SHALL in SCAN add one word per cycle to checksum (index 0..DEPTH-1, invalid words add 0, mod 2^64 wrap), then go SCAN->DONE after index DEPTH-1 is added.
REQ-022 SHALL produce done=1 exactly DEPTH+1 edges after the halt-sampling edge (1025 for default), held in DONE until rst; halt deassertion is ignored after RUN.
REQ-023 SHALL ignore stores in SCAN/DONE (no word change, no count, no addr_err).
REQ-024 SHALL keep checksum stable in DONE; its value in SCAN is a partial sum, valid only while done=1.

Reset
REQ-025 SHALL on rst=1, at any time including mid-SCAN: state=RUN, all valid bits=0, done=0, checksum=0, wr_count=0, addr_err=0, mem_data high-Z; word contents need not be cleared.
REQ-026 SHALL, after rst falls, accept a store on the first rising clk edge.

Verification
REQ-027 SHALL cover: rst, then read addr 0x40 with mem_rw=0 -> mem_data=0; store 0x1122334455667788 to addr 0x40 -> next-cycle read of 0x40 or 0x47 returns that value, wr_count=1.
REQ-028 SHALL cover: CPU drives mem_data with mem_rw=1 -> block output high-Z, no contention (no X on bus).
REQ-029 SHALL cover: store to addr 0x2000 -> addr_err=1, wr_count unchanged, read of 0x2000 returns 0.
REQ-030 SHALL cover: stores of 5, 7, 0xFFFFFFFFFFFFFFFF to words 0,1,1023, then halt=1 -> done rises after 1025 edges, checksum=0x000000000000000B.
REQ-031 SHALL cover: rst pulse at scan cycle 300 -> done=0, checksum=0, state RUN immediately; a read of word 0 returns 0.
REQ-032 SHALL cover: 65536 stores -> wr_count wraps to 0; a store during DONE leaves the word and the count unchanged.

Source files
------------

// File: rtl/data_mem.sv
// Data memory for a simple CPU: word-addressed storage with a shared bidirectional
// data bus, sticky range-error flag, store counter and a post-halt checksum scan.
module data_mem #(
   parameter int DEPTH = 1024
) (
   input  logic        clk,
   input  logic        rst,
   inout  wire  [63:0] mem_data,
   input  logic        mem_rw,
   input  logic [63:0] addr,
   input  logic        halt,
   output logic        done,
   output logic [63:0] checksum,
   output logic [15:0] wr_count,
   output logic        addr_err
);

   localparam int IW = $clog2(DEPTH);

   typedef enum logic [1:0] {S_RUN, S_SCAN, S_DONE} state_t;

   state_t          state;
   state_t          next_state;
   logic [63:0]     mem [DEPTH];
   logic [DEPTH-1:0] valid;
   logic [IW-1:0]   scan_idx;
   logic [IW-1:0]   idx;
   logic            in_range;
   logic            bus_en;
   logic            store_en;
   logic            bad_store;
   logic            scan_en;
   logic [63:0]     rd_data;
   logic [63:0]     scan_word;
   logic            unused_ok;

   // Byte address -> word index; the low three bits only select a byte inside the word.
   assign idx       = addr[IW+2:3];
   assign in_range  = (addr[63:IW+3] == '0);
   assign unused_ok = &{1'b0, addr[2:0]};

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_RUN;
      else     state <= next_state;
   end

   // Next-state logic: halt starts the scan, the last index ends it, DONE holds until reset.
   always_comb begin
      next_state = state;
      case (state)
         S_RUN:   if (halt) next_state = S_SCAN;
         S_SCAN:  if (scan_idx == IW'(DEPTH - 1)) next_state = S_DONE;
         S_DONE:  next_state = S_DONE;
         default: next_state = S_RUN;
      endcase
   end

   // Output decode: the bus is only driven while running and the CPU is not storing.
   always_comb begin
      bus_en    = (state == S_RUN) && !mem_rw && !rst;
      store_en  = (state == S_RUN) && mem_rw && in_range;
      bad_store = (state == S_RUN) && mem_rw && !in_range;
      scan_en   = (state == S_SCAN);
   end

   // Zero-latency read path; unwritten or out-of-range words read as zero.
   assign rd_data   = (in_range && valid[idx]) ? mem[idx] : '0;
   assign scan_word = valid[scan_idx] ? mem[scan_idx] : '0;
   assign mem_data  = bus_en ? rd_data : 'z;

   // Word storage.
   // NOTE: the data array has no reset; the per-word valid bits make stale contents invisible.
   always_ff @(posedge clk) begin
      if (store_en) mem[idx] <= mem_data;
   end

   // Control and status registers: valid bits, store count, error flag, scan datapath, done.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid    <= '0;
         wr_count <= '0;
         addr_err <= 1'b0;
         scan_idx <= '0;
         checksum <= '0;
         done     <= 1'b0;
      end else begin
         if (store_en) begin
            valid[idx] <= 1'b1;
            wr_count   <= wr_count + 16'd1;
         end
         if (bad_store) addr_err <= 1'b1;
         if (state == S_RUN && halt) begin
            scan_idx <= '0;
            checksum <= '0;
         end else if (scan_en) begin
            checksum <= checksum + scan_word;
            scan_idx <= scan_idx + IW'(1);
         end
         // done follows DONE by one edge, landing DEPTH+1 edges after the halt edge.
         done <= (state == S_DONE);
      end
   end

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem.
module tb_data_mem;

   logic        clk;
   logic        rst;
   wire  [63:0] mem_data;
   logic        mem_rw;
   logic [63:0] addr;
   logic        halt;
   logic        done;
   logic [63:0] checksum;
   logic [15:0] wr_count;
   logic        addr_err;

   logic        cpu_drive;
   logic [63:0] cpu_val;

   int vectors = 0;
   int errors  = 0;

   assign mem_data = cpu_drive ? cpu_val : 'z;

   data_mem dut (
      .clk      (clk),
      .rst      (rst),
      .mem_data (mem_data),
      .mem_rw   (mem_rw),
      .addr     (addr),
      .halt     (halt),
      .done     (done),
      .checksum (checksum),
      .wr_count (wr_count),
      .addr_err (addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [63:0] a, input logic [63:0] d);
      addr      = a;
      cpu_val   = d;
      mem_rw    = 1'b1;
      cpu_drive = 1'b1;
      tick();
      mem_rw    = 1'b0;
      cpu_drive = 1'b0;
   endtask

   task automatic read(input logic [63:0] a, output logic [63:0] d);
      addr   = a;
      mem_rw = 1'b0;
      #1;
      d = mem_data;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #3;
      rst = 1'b0;
      #1;
   endtask

   logic [63:0] rd;

   initial begin
      rst       = 1'b1;
      mem_rw    = 1'b0;
      addr      = '0;
      halt      = 1'b0;
      cpu_drive = 1'b0;
      cpu_val   = '0;
      #2;
      check("rst_done",     {63'd0, done},     64'd0);
      check("rst_checksum", checksum,          64'd0);
      check("rst_wr_count", {48'd0, wr_count}, 64'd0);
      check("rst_addr_err", {63'd0, addr_err}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Unwritten word reads zero; store then read back, ignoring byte offset.
      read(64'h40, rd);
      check("read_unwritten", rd, 64'd0);
      store(64'h40, 64'h1122334455667788);
      check("wr_count_1", {48'd0, wr_count}, 64'd1);
      read(64'h40, rd);
      check("read_0x40", rd, 64'h1122334455667788);
      read(64'h47, rd);
      check("read_0x47", rd, 64'h1122334455667788);

      // CPU owns the bus while storing: value seen must be exactly the CPU's.
      addr      = 64'h40;
      cpu_val   = 64'hDEADBEEF0BADF00D;
      mem_rw    = 1'b1;
      cpu_drive = 1'b1;
      #1;
      check("bus_cpu_owned", mem_data, 64'hDEADBEEF0BADF00D);
      tick();
      mem_rw    = 1'b0;
      cpu_drive = 1'b0;
      check("wr_count_2", {48'd0, wr_count}, 64'd2);
      read(64'h40, rd);
      check("read_overwrite", rd, 64'hDEADBEEF0BADF00D);

      // Out-of-range store: flagged, discarded, uncounted.
      store(64'h2000, 64'h123);
      check("oor_addr_err", {63'd0, addr_err}, 64'd1);
      check("oor_wr_count", {48'd0, wr_count}, 64'd2);
      read(64'h2000, rd);
      check("oor_read", rd, 64'd0);
      tick();
      check("addr_err_sticky", {63'd0, addr_err}, 64'd1);

      // Store counter wraps after 65536 stores.
      do_reset();
      check("reset_clears_err", {63'd0, addr_err}, 64'd0);
      for (int i = 0; i < 65535; i++) store(64'h0, 64'(i));
      check("wr_count_ffff", {48'd0, wr_count}, 64'hFFFF);
      store(64'h0, 64'h0);
      check("wr_count_wrap", {48'd0, wr_count}, 64'd0);

      // Checksum scan: 5 + 7 + all-ones = 0xB mod 2^64.
      store(64'h0,    64'd5);
      store(64'h8,    64'd7);
      store(64'h1FF8, 64'hFFFFFFFFFFFFFFFF);
      check("wr_count_3", {48'd0, wr_count}, 64'd3);
      halt = 1'b1;
      tick();                                   // halt-sampling edge
      halt = 1'b0;                              // ignored after RUN
      for (int i = 0; i < 1024; i++) tick();
      check("done_not_early", {63'd0, done}, 64'd0);
      tick();                                   // edge 1025 after halt edge
      check("done_1025", {63'd0, done}, 64'd1);
      check("checksum_b", checksum, 64'h000000000000000B);

      // Stores during DONE are ignored entirely.
      store(64'h0, 64'd99);
      store(64'h2000, 64'd1);
      check("done_store_count", {48'd0, wr_count}, 64'd3);
      check("done_store_err",   {63'd0, addr_err}, 64'd0);
      check("done_held",        {63'd0, done},     64'd1);
      check("checksum_stable",  checksum,          64'h000000000000000B);

      // Reset in the middle of a scan.
      do_reset();
      store(64'h0, 64'd5);
      store(64'h8, 64'd7);
      halt = 1'b1;
      tick();
      halt = 1'b0;
      for (int i = 0; i < 300; i++) tick();
      rst = 1'b1;
      #1;
      check("midscan_done",     {63'd0, done},     64'd0);
      check("midscan_checksum", checksum,          64'd0);
      check("midscan_wr_count", {48'd0, wr_count}, 64'd0);
      rst = 1'b0;
      #1;
      read(64'h0, rd);
      check("midscan_read_w0", rd, 64'd0);
      store(64'h0, 64'h55);                     // first edge after reset release
      check("post_rst_count", {48'd0, wr_count}, 64'd1);
      read(64'h0, rd);
      check("post_rst_read", rd, 64'h55);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
